// File: rtl/dmem_rd_streamer_if.sv
// Bundle of the command, memory-port and output-stream signals of the
// data-memory read streamer. The master modport is the streamer itself;
// the slave modport is everything around it (command source, memory, consumer).
interface dmem_rd_streamer_if #(
    parameter int data_width = 32,
    parameter int addr_width = 15,
    parameter int len_width  = 16
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [addr_width-1:0] cmd_addr;
    logic [len_width-1:0]  cmd_len;

    logic                  mem_en;
    logic                  mem_we;
    logic [addr_width-1:0] mem_addr;
    logic [data_width-1:0] mem_wdata;
    logic [data_width-1:0] mem_rdata;

    logic                  valid;
    logic                  ready;
    logic [data_width-1:0] data;
    logic                  last;
    logic                  done;
    logic                  err;

    modport master (
        input  cmd_valid, cmd_addr, cmd_len, mem_rdata, ready,
        output cmd_ready, mem_en, mem_we, mem_addr, mem_wdata,
               valid, data, last, done, err
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_len, mem_rdata, ready,
        input  cmd_ready, mem_en, mem_we, mem_addr, mem_wdata,
               valid, data, last, done, err
    );
endinterface

// File: rtl/dmem_rd_streamer.sv
// Read-side streaming engine for one port of the 32-bit data memory.
// Takes an (address, length) command, issues sequential reads, absorbs the
// one-cycle memory latency in a credit-managed FIFO and presents the words
// as a valid/ready stream with a last marker and a completion pulse.
// Build option: define DMEM_RD_WRAP_EN to let ranges wrap past the top of
// memory; without it, ranges that overrun memory are rejected with err.
module dmem_rd_streamer #(
    parameter int data_width = 32,
    parameter int addr_width = 15,
    parameter int len_width  = 16,
    parameter int fifo_depth = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    dmem_rd_streamer_if.master   bus
);
    localparam int ptr_width = $clog2(fifo_depth);
    localparam int cnt_width = ptr_width + 2;

    localparam logic [1:0] st_idle  = 2'd0;
    localparam logic [1:0] st_run   = 2'd1;
    localparam logic [1:0] st_drain = 2'd2;

    logic [1:0]            state;
    logic [addr_width-1:0] next_addr;
    logic [len_width-1:0]  len_q;
    logic [len_width-1:0]  issued;
    logic [len_width-1:0]  popped;

    logic                  mem_en_q;
    logic [addr_width-1:0] mem_addr_q;
    logic                  pending;

    logic [data_width-1:0] fifo_mem [fifo_depth];
    logic [ptr_width-1:0]  wr_ptr;
    logic [ptr_width-1:0]  rd_ptr;
    logic [cnt_width-1:0]  count;

    logic                  zero_done;

    logic                  accept;
    logic                  reject;
    logic                  fifo_nonempty;
    logic                  pop;
    logic                  push;
    logic                  head_last;
    logic                  issue;
    logic [cnt_width-1:0]  committed;

    assign accept = (state == st_idle) && bus.cmd_valid;

`ifdef DMEM_RD_WRAP_EN
    assign reject  = 1'b0;
    assign bus.err = 1'b0;
`else
    localparam logic [len_width:0] addr_space = (len_width+1)'(1) << addr_width;

    logic [len_width:0] range_end;
    logic               err_q;

    // The overrun test is done one bit wider than the length so a range
    // ending exactly at the top of memory is still legal.
    assign range_end = {1'b0, bus.cmd_len}
                     + {{(len_width + 1 - addr_width){1'b0}}, bus.cmd_addr};
    assign reject    = range_end > addr_space;
    assign bus.err   = err_q;

    // Rejected commands are still handshaken; flag them one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= accept && reject;
        end
    end
`endif

    assign fifo_nonempty = (count != '0);
    assign pop           = fifo_nonempty && bus.ready;
    assign push          = pending;
    assign head_last     = fifo_nonempty && (popped == len_q - len_width'(1));

    // Everything already promised a FIFO slot: stored words, the read being
    // presented to memory and the read whose data arrives next edge. A pop
    // this cycle frees its slot immediately so streaming runs at full rate.
    assign committed = count + cnt_width'(mem_en_q) + cnt_width'(pending)
                     - cnt_width'(pop);
    assign issue     = (state == st_run) && (issued < len_q)
                     && (committed < cnt_width'(fifo_depth));

    // Command sequencing: latch commands, walk the address, track progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= st_idle;
            next_addr <= '0;
            len_q     <= '0;
            issued    <= '0;
            popped    <= '0;
        end else begin
            if (pop) begin
                popped <= popped + len_width'(1);
            end
            case (state)
                st_idle: begin
                    if (accept && !reject && (bus.cmd_len != '0)) begin
                        state     <= st_run;
                        next_addr <= bus.cmd_addr;
                        len_q     <= bus.cmd_len;
                        issued    <= '0;
                        popped    <= '0;
                    end
                end
                st_run: begin
                    if (issue) begin
                        next_addr <= next_addr + addr_width'(1);
                        issued    <= issued + len_width'(1);
                        if (issued + len_width'(1) == len_q) begin
                            state <= st_drain;
                        end
                    end
                end
                st_drain: begin
                    if (pop && head_last) begin
                        state <= st_idle;
                    end
                end
                default: state <= st_idle;
            endcase
        end
    end

    // Registered memory request plus a one-deep marker for the read in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_en_q   <= 1'b0;
            mem_addr_q <= '0;
            pending    <= 1'b0;
        end else begin
            mem_en_q <= issue;
            if (issue) begin
                mem_addr_q <= next_addr;
            end
            pending <= mem_en_q;
        end
    end

    // FIFO pointers and occupancy; the credit check guarantees no overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ptr_width'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ptr_width'(1);
            end
            count <= count + cnt_width'(push) - cnt_width'(pop);
        end
    end

    // FIFO storage captures the memory word the cycle after each read.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= bus.mem_rdata;
        end
    end

    // A zero-length command completes on its own one cycle after acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            zero_done <= 1'b0;
        end else begin
            zero_done <= accept && !reject && (bus.cmd_len == '0);
        end
    end

    assign bus.cmd_ready = (state == st_idle);
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = 1'b0;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = '0;
    assign bus.valid     = fifo_nonempty;
    assign bus.data      = fifo_nonempty ? fifo_mem[rd_ptr] : '0;
    assign bus.last      = head_last;
    assign bus.done      = zero_done || (pop && head_last);
endmodule

// File: tb/tb_dmem_rd_streamer.sv
// Directed bench for dmem_rd_streamer: memory model returns 0x100 + address,
// a negedge monitor records issued addresses and popped words, and one
// linear initial block applies commands and asserts on observed values.
module tb_dmem_rd_streamer;
    logic clk = 1'b0;
    logic rst = 1'b1;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] words [$];
    logic        lasts [$];
    logic [14:0] addrs [$];
    int          done_count  = 0;
    int          outstanding = 0;
    int          max_out     = 0;
    int          stall_err   = 0;
    logic        prev_stall  = 1'b0;
    logic [31:0] prev_data   = '0;
    logic        prev_last   = 1'b0;

    dmem_rd_streamer_if #(.data_width(32), .addr_width(15), .len_width(16)) bus ();

    dmem_rd_streamer #(
        .data_width(32),
        .addr_width(15),
        .len_width (16),
        .fifo_depth(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Memory model with one-cycle read latency: word at address a is 0x100 + a.
    always @(posedge clk) begin
        if (bus.mem_en) begin
            bus.mem_rdata <= 32'h100 + {17'd0, bus.mem_addr};
        end
    end

    // Monitor sampled mid-cycle: reads, pops, done pulses, credit and stall stability.
    always @(negedge clk) begin
        if (rst) begin
            outstanding = 0;
            prev_stall  = 1'b0;
        end else begin
            if (prev_stall && (bus.valid !== 1'b1 || bus.data !== prev_data
                               || bus.last !== prev_last)) begin
                stall_err++;
            end
            if (bus.mem_en) begin
                addrs.push_back(bus.mem_addr);
                outstanding++;
            end
            if (bus.valid && bus.ready) begin
                words.push_back(bus.data);
                lasts.push_back(bus.last);
                outstanding--;
            end
            if (bus.done) begin
                done_count++;
            end
            if (outstanding > max_out) begin
                max_out = outstanding;
            end
            prev_stall = bus.valid && !bus.ready;
            prev_data  = bus.data;
            prev_last  = bus.last;
        end
    end

    task automatic check(input string tag, input logic [63:0] observed,
                         input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [14:0] addr, input logic [15:0] len);
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = addr;
        bus.cmd_len   = len;
        #1;
        check("cmd_ready_at_offer", 64'(bus.cmd_ready), 64'd1);
        step();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input logic [3:0] pat, input int budget);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            bus.ready = pat[i % 4];
            #1;
            if (bus.done) begin
                seen = 1'b1;
            end
            step();
        end
        check("done_seen", 64'(seen), 64'd1);
    endtask

    initial begin
        int base;
        int abase;
        int dbase;

        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_len   = '0;
        bus.ready     = 1'b0;
        step();
        step();

        // Reset state.
        check("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        check("rst_mem_en",    64'(bus.mem_en),    64'd0);
        check("rst_mem_addr",  64'(bus.mem_addr),  64'd0);
        check("rst_valid",     64'(bus.valid),     64'd0);
        check("rst_done",      64'(bus.done),      64'd0);
        check("rst_err",       64'(bus.err),       64'd0);
        rst = 1'b0;
        step();

        // Full-rate stream of 8 words from 0x10.
        send_cmd(15'h0010, 16'd8);
        bus.ready = 1'b1;
        check("t1_valid_e0", 64'(bus.valid), 64'd0);
        step();
        check("t1_valid_e1", 64'(bus.valid), 64'd0);
        step();
        check("t1_valid_e2", 64'(bus.valid), 64'd0);
        step();
        for (int k = 0; k < 8; k++) begin
            #1;
            check("t1_valid", 64'(bus.valid), 64'd1);
            check("t1_data",  64'(bus.data),  64'(32'h110 + k));
            check("t1_last",  64'(bus.last),  64'(k == 7));
            check("t1_done",  64'(bus.done),  64'(k == 7));
            step();
        end
        check("t1_valid_after", 64'(bus.valid),     64'd0);
        check("t1_done_after",  64'(bus.done),      64'd0);
        check("t1_idle_after",  64'(bus.cmd_ready), 64'd1);

        // Same command with an initial stall, then ready toggling 1,0,0,1.
        base = words.size();
        send_cmd(15'h0010, 16'd8);
        bus.ready = 1'b0;
        repeat (10) step();
        check("t2_stall_mem_en", 64'(bus.mem_en), 64'd0);
        check("t2_stall_valid",  64'(bus.valid),  64'd1);
        check("t2_stall_head",   64'(bus.data),   64'h110);
        check("t2_stall_credit", 64'(outstanding), 64'd4);
        wait_done(4'b1001, 100);
        check("t2_count", 64'(words.size() - base), 64'd8);
        for (int k = 0; k < 8; k++) begin
            if (base + k < words.size()) begin
                check("t2_data", 64'(words[base + k]), 64'(32'h110 + k));
                check("t2_last", 64'(lasts[base + k]), 64'(k == 7));
            end
        end
        check("t2_stall_stable", 64'(stall_err), 64'd0);
        check("t2_max_outstanding_ok", 64'(max_out <= 4), 64'd1);
        bus.ready = 1'b0;

        // Zero-length command.
        abase = addrs.size();
        dbase = done_count;
        send_cmd(15'h0123, 16'd0);
        #1;
        check("t3_done_pulse", 64'(bus.done),      64'd1);
        check("t3_valid",      64'(bus.valid),     64'd0);
        check("t3_idle",       64'(bus.cmd_ready), 64'd1);
        step();
        check("t3_done_end",   64'(bus.done),      64'd0);
        repeat (4) step();
        check("t3_no_reads",   64'(addrs.size() - abase), 64'd0);
        check("t3_one_done",   64'(done_count - dbase),   64'd1);

        // Range crossing the top of memory.
        abase = addrs.size();
        base  = words.size();
        dbase = done_count;
        send_cmd(15'h7FFE, 16'd4);
`ifdef DMEM_RD_WRAP_EN
        check("t4_err", 64'(bus.err), 64'd0);
        wait_done(4'b1111, 30);
        check("t4_read_count", 64'(addrs.size() - abase), 64'd4);
        check("t4_word_count", 64'(words.size() - base),  64'd4);
        if (addrs.size() - abase >= 4 && words.size() - base >= 4) begin
            check("t4_addr0", 64'(addrs[abase + 0]), 64'h7FFE);
            check("t4_addr1", 64'(addrs[abase + 1]), 64'h7FFF);
            check("t4_addr2", 64'(addrs[abase + 2]), 64'h0000);
            check("t4_addr3", 64'(addrs[abase + 3]), 64'h0001);
            check("t4_word0", 64'(words[base + 0]),  64'h80FE);
            check("t4_word2", 64'(words[base + 2]),  64'h0100);
        end
`else
        check("t4_err_pulse", 64'(bus.err),       64'd1);
        check("t4_idle",      64'(bus.cmd_ready), 64'd1);
        step();
        check("t4_err_end",   64'(bus.err),       64'd0);
        bus.ready = 1'b1;
        repeat (6) step();
        check("t4_no_reads",  64'(addrs.size() - abase), 64'd0);
        check("t4_no_done",   64'(done_count - dbase),   64'd0);
        check("t4_no_valid",  64'(bus.valid),            64'd0);
`endif

        // Reset in the middle of a 16-word command after 3 pops.
        base  = words.size();
        dbase = done_count;
        send_cmd(15'h0040, 16'd16);
        bus.ready = 1'b1;
        for (int i = 0; i < 20 && (words.size() - base) < 3; i++) begin
            step();
        end
        check("t5_three_popped", 64'(words.size() - base), 64'd3);
        rst       = 1'b1;
        bus.ready = 1'b0;
        step();
        check("t5_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        check("t5_mem_en",    64'(bus.mem_en),    64'd0);
        check("t5_mem_addr",  64'(bus.mem_addr),  64'd0);
        check("t5_valid",     64'(bus.valid),     64'd0);
        check("t5_last",      64'(bus.last),      64'd0);
        check("t5_done",      64'(bus.done),      64'd0);
        check("t5_err",       64'(bus.err),       64'd0);
        check("t5_data",      64'(bus.data),      64'd0);
        rst = 1'b0;
        step();
        check("t5_no_done_abort", 64'(done_count - dbase), 64'd0);
        base = words.size();
        send_cmd(15'h0020, 16'd2);
        wait_done(4'b1111, 30);
        check("t5_count", 64'(words.size() - base), 64'd2);
        if (words.size() - base >= 2) begin
            check("t5_word0", 64'(words[base + 0]), 64'h120);
            check("t5_word1", 64'(words[base + 1]), 64'h121);
        end

        // Command held valid during RUN with a different address.
        base  = words.size();
        abase = addrs.size();
        send_cmd(15'h0030, 16'd4);
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = 15'h0050;
        bus.cmd_len   = 16'd2;
        #1;
        check("t6_busy_ready", 64'(bus.cmd_ready), 64'd0);
        wait_done(4'b1111, 30);
        check("t6_rearm_ready",  64'(bus.cmd_ready), 64'd1);
        check("t6_first_words",  64'(words.size() - base),  64'd4);
        check("t6_first_reads",  64'(addrs.size() - abase), 64'd4);
        step();
        bus.cmd_valid = 1'b0;
        wait_done(4'b1111, 30);
        check("t6_count", 64'(words.size() - base), 64'd6);
        if (words.size() - base >= 6) begin
            check("t6_word0", 64'(words[base + 0]), 64'h130);
            check("t6_word3", 64'(words[base + 3]), 64'h133);
            check("t6_word4", 64'(words[base + 4]), 64'h150);
            check("t6_word5", 64'(words[base + 5]), 64'h151);
        end
        check("final_stall_stable",    64'(stall_err),    64'd0);
        check("final_max_outstanding", 64'(max_out <= 4), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
